// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller: pairs in-order instructions onto the even/odd pipes,
// gating issue on a per-register latency countdown scoreboard.
module dual_issue_ctrl #(
  parameter int PAYLOAD_W      = 64,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int LAT_W          = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      i0_pipe,
  input  logic                      i0_wr,
  input  logic [REG_ADDR_WIDTH-1:0] i0_rt,
  input  logic [REG_ADDR_WIDTH-1:0] i0_ra,
  input  logic [REG_ADDR_WIDTH-1:0] i0_rb,
  input  logic [REG_ADDR_WIDTH-1:0] i0_rc,
  input  logic [2:0]                i0_use,
  input  logic [LAT_W-1:0]          i0_lat,
  input  logic                      i0_br,
  input  logic [PAYLOAD_W-1:0]      i0_payload,
  input  logic                      i1_pipe,
  input  logic                      i1_wr,
  input  logic [REG_ADDR_WIDTH-1:0] i1_rt,
  input  logic [REG_ADDR_WIDTH-1:0] i1_ra,
  input  logic [REG_ADDR_WIDTH-1:0] i1_rb,
  input  logic [REG_ADDR_WIDTH-1:0] i1_rc,
  input  logic [2:0]                i1_use,
  input  logic [LAT_W-1:0]          i1_lat,
  input  logic                      i1_br,
  input  logic [PAYLOAD_W-1:0]      i1_payload,
  input  logic                      branch_taken,
  output logic                      even_valid,
  output logic [PAYLOAD_W-1:0]      even_payload,
  output logic                      odd_valid,
  output logic [PAYLOAD_W-1:0]      odd_payload,
  output logic                      br_first_instr,
  output logic [15:0]               stall_cycles
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} state_t;

  typedef struct packed {
    logic                      pipe;
    logic                      wr;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [REG_ADDR_WIDTH-1:0] rb;
    logic [REG_ADDR_WIDTH-1:0] rc;
    logic [2:0]                usem;
    logic [LAT_W-1:0]          lat;
    logic                      br;
    logic [PAYLOAD_W-1:0]      payload;
  } instr_t;

  function automatic logic srcs_ready(input logic [2:0] usem, input logic [LAT_W-1:0] ea,
                                      input logic [LAT_W-1:0] eb, input logic [LAT_W-1:0] ec);
    return (!usem[2] || ea == '0) && (!usem[1] || eb == '0) && (!usem[0] || ec == '0);
  endfunction

  state_t               state_q, state_d;
  instr_t               hold_q, hold_d;
  logic [LAT_W-1:0]     sb_q [NREG];
  logic [LAT_W-1:0]     sb_d [NREG];
  logic                 even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
  logic [PAYLOAD_W-1:0] even_payload_q, even_payload_d, odd_payload_q, odd_payload_d;
  logic                 br_first_q, br_first_d;
  logic [15:0]          stall_q, stall_d;

  instr_t i0, i1, src_a;
  logic   a_rdy, i1_rdy, i1_raw, i1_waw, dual_ok;
  logic   accept, a_issue, b_issue, stall;

  assign i0 = {i0_pipe, i0_wr, i0_rt, i0_ra, i0_rb, i0_rc, i0_use, i0_lat, i0_br, i0_payload};
  assign i1 = {i1_pipe, i1_wr, i1_rt, i1_ra, i1_rb, i1_rc, i1_use, i1_lat, i1_br, i1_payload};

  // Slot A is i0 in RUN and the held instruction in HOLD; slot B is only ever a dual-issued i1.
  assign src_a  = (state_q == ST_HOLD) ? hold_q : i0;
  assign a_rdy  = srcs_ready(src_a.usem, sb_q[src_a.ra], sb_q[src_a.rb], sb_q[src_a.rc]);
  assign i1_rdy = srcs_ready(i1.usem, sb_q[i1.ra], sb_q[i1.rb], sb_q[i1.rc]);
  assign i1_raw = i0.wr && ((i1.usem[2] && i1.ra == i0.rt) ||
                            (i1.usem[1] && i1.rb == i0.rt) ||
                            (i1.usem[0] && i1.rc == i0.rt));
  assign i1_waw = i0.wr && i1.wr && (i1.rt == i0.rt);
  assign dual_ok = (i1.pipe != i0.pipe) && i1_rdy && !i1_raw && !i1_waw;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    a_issue = 1'b0;
    b_issue = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
          hold_d  = '0;
        end else if (in_valid && a_rdy) begin
          accept  = 1'b1;
          a_issue = 1'b1;
          if (dual_ok) begin
            b_issue = 1'b1;
          end else begin
            hold_d  = i1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
          hold_d  = '0;
        end else if (a_rdy) begin
          a_issue = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign in_ready = accept && reset;

  always_comb begin
    even_valid_d   = 1'b0;
    odd_valid_d    = 1'b0;
    even_payload_d = even_payload_q;
    odd_payload_d  = odd_payload_q;
    if (a_issue) begin
      if (src_a.pipe) begin
        odd_valid_d   = 1'b1;
        odd_payload_d = src_a.payload;
      end else begin
        even_valid_d   = 1'b1;
        even_payload_d = src_a.payload;
      end
    end
    if (b_issue) begin
      if (i1.pipe) begin
        odd_valid_d   = 1'b1;
        odd_payload_d = i1.payload;
      end else begin
        even_valid_d   = 1'b1;
        even_payload_d = i1.payload;
      end
    end
    br_first_d = b_issue && src_a.br;
    stall      = !branch_taken && !a_issue &&
                 ((state_q == ST_RUN && in_valid) || state_q == ST_HOLD);
    stall_d    = (stall && stall_q != '1) ? stall_q + 16'd1 : stall_q;
  end

  always_comb begin
    sb_d = sb_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (sb_q[r] != '0) sb_d[r] = sb_q[r] - LAT_W'(1);
    end
    if (a_issue && src_a.wr && src_a.lat != '0 && src_a.lat > sb_d[src_a.rt])
      sb_d[src_a.rt] = src_a.lat;
    if (b_issue && i1.wr && i1.lat != '0 && i1.lat > sb_d[i1.rt])
      sb_d[i1.rt] = i1.lat;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      hold_q         <= '0;
      sb_q           <= '{default: '0};
      even_valid_q   <= 1'b0;
      odd_valid_q    <= 1'b0;
      even_payload_q <= '0;
      odd_payload_q  <= '0;
      br_first_q     <= 1'b0;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      sb_q           <= sb_d;
      even_valid_q   <= even_valid_d;
      odd_valid_q    <= odd_valid_d;
      even_payload_q <= even_payload_d;
      odd_payload_q  <= odd_payload_d;
      br_first_q     <= br_first_d;
      stall_q        <= stall_d;
    end
  end

  assign even_valid     = even_valid_q;
  assign odd_valid      = odd_valid_q;
  assign even_payload   = even_payload_q;
  assign odd_payload    = odd_payload_q;
  assign br_first_instr = br_first_q;
  assign stall_cycles   = stall_q;
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Self-checking bench for dual_issue_ctrl: directed pairs with per-cycle
// expected issue records queued at drive time and compared after the edge.
module tb_dual_issue_ctrl;
  localparam int PW = 64;
  localparam int RW = 7;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, in_ready, branch_taken;
  logic          i0_pipe, i0_wr, i0_br, i1_pipe, i1_wr, i1_br;
  logic [RW-1:0] i0_rt, i0_ra, i0_rb, i0_rc, i1_rt, i1_ra, i1_rb, i1_rc;
  logic [2:0]    i0_use, i1_use;
  logic [LW-1:0] i0_lat, i1_lat;
  logic [PW-1:0] i0_payload, i1_payload;
  logic          even_valid, odd_valid, br_first_instr;
  logic [PW-1:0] even_payload, odd_payload;
  logic [15:0]   stall_cycles;

  dual_issue_ctrl #(.PAYLOAD_W(PW), .REG_ADDR_WIDTH(RW), .LAT_W(LW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .i0_pipe(i0_pipe), .i0_wr(i0_wr), .i0_rt(i0_rt), .i0_ra(i0_ra), .i0_rb(i0_rb),
    .i0_rc(i0_rc), .i0_use(i0_use), .i0_lat(i0_lat), .i0_br(i0_br), .i0_payload(i0_payload),
    .i1_pipe(i1_pipe), .i1_wr(i1_wr), .i1_rt(i1_rt), .i1_ra(i1_ra), .i1_rb(i1_rb),
    .i1_rc(i1_rc), .i1_use(i1_use), .i1_lat(i1_lat), .i1_br(i1_br), .i1_payload(i1_payload),
    .branch_taken(branch_taken), .even_valid(even_valid), .even_payload(even_payload),
    .odd_valid(odd_valid), .odd_payload(odd_payload), .br_first_instr(br_first_instr),
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic          ev;
    logic [PW-1:0] ep;
    logic          ov;
    logic [PW-1:0] op;
    logic          bf;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic set_i0(input int p, input int w, input int rt, input int ra, input int rb,
                        input int rc, input int u, input int lt, input int b, input logic [PW-1:0] pl);
    i0_pipe = 1'(p); i0_wr = 1'(w); i0_rt = RW'(rt); i0_ra = RW'(ra); i0_rb = RW'(rb);
    i0_rc = RW'(rc); i0_use = 3'(u); i0_lat = LW'(lt); i0_br = 1'(b); i0_payload = pl;
  endtask

  task automatic set_i1(input int p, input int w, input int rt, input int ra, input int rb,
                        input int rc, input int u, input int lt, input int b, input logic [PW-1:0] pl);
    i1_pipe = 1'(p); i1_wr = 1'(w); i1_rt = RW'(rt); i1_ra = RW'(ra); i1_rb = RW'(rb);
    i1_rc = RW'(rc); i1_use = 3'(u); i1_lat = LW'(lt); i1_br = 1'(b); i1_payload = pl;
  endtask

  // Called just after a rising edge with inputs already driven for the coming cycle.
  task automatic step(input int rdy, input int ev, input logic [PW-1:0] ep,
                      input int ov, input logic [PW-1:0] op, input int bf);
    exp_t e;
    #3;
    check("in_ready", 64'(in_ready), 64'(rdy));
    e.ev = (ev != 0); e.ep = ep; e.ov = (ov != 0); e.op = op; e.bf = (bf != 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("even_valid", 64'(even_valid), 64'(e.ev));
    if (e.ev) check("even_payload", even_payload, e.ep);
    check("odd_valid", 64'(odd_valid), 64'(e.ov));
    if (e.ov) check("odd_payload", odd_payload, e.op);
    check("br_first_instr", 64'(br_first_instr), 64'(e.bf));
  endtask

  task automatic idle(input int rdy);
    step(rdy, 0, '0, 0, '0, 0);
  endtask

  localparam logic [PW-1:0] P_A0 = 64'hA000_0000_0000_00A0, P_A1 = 64'hA100_0000_0000_00A1;
  localparam logic [PW-1:0] P_B0 = 64'hB000_0000_0000_00B0, P_B1 = 64'hB100_0000_0000_00B1;
  localparam logic [PW-1:0] P_C0 = 64'hC000_0000_0000_00C0, P_C1 = 64'hC100_0000_0000_00C1;
  localparam logic [PW-1:0] P_C2 = 64'hC200_0000_0000_00C2, P_C3 = 64'hC300_0000_0000_00C3;
  localparam logic [PW-1:0] P_D0 = 64'hD000_0000_0000_00D0, P_D1 = 64'hD100_0000_0000_00D1;
  localparam logic [PW-1:0] P_E0 = 64'hE000_0000_0000_00E0, P_E1 = 64'hE100_0000_0000_00E1;
  localparam logic [PW-1:0] P_E2 = 64'hE200_0000_0000_00E2, P_E3 = 64'hE300_0000_0000_00E3;
  localparam logic [PW-1:0] P_F0 = 64'hF000_0000_0000_00F0, P_F1 = 64'hF100_0000_0000_00F1;
  localparam logic [PW-1:0] P_F2 = 64'hF200_0000_0000_00F2, P_F3 = 64'hF300_0000_0000_00F3;
  localparam logic [PW-1:0] P_G0 = 64'h9000_0000_0000_0090, P_G1 = 64'h9100_0000_0000_0091;
  localparam logic [PW-1:0] P_G2 = 64'h9200_0000_0000_0092, P_G3 = 64'h9300_0000_0000_0093;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; branch_taken = 1'b0;
    set_i0(0, 1, 3, 0, 0, 0, 0, 2, 0, P_A0);
    set_i1(1, 0, 0, 0, 0, 0, 0, 0, 0, P_A1);
    @(posedge clk);
    #1;

    // Reset with a ready pair offered: nothing accepted, everything cleared
    in_valid = 1'b1;
    idle(0);
    idle(0);
    check("rst_even_payload", even_payload, '0);
    check("rst_odd_payload", odd_payload, '0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    reset = 1'b1;

    // Independent dual pair
    set_i0(0, 1, 3, 1, 2, 0, 3'b000, 2, 0, P_A0);
    set_i1(1, 1, 4, 10, 11, 0, 3'b110, 1, 0, P_A1);
    in_valid = 1'b1;
    step(1, 1, P_A0, 1, P_A1, 0);
    in_valid = 1'b0;
    repeat (3) idle(0);

    // Intra-pair RAW: i1 held, issues lat(i0)=3 cycles after the decision cycle
    set_i0(0, 1, 5, 0, 0, 0, 3'b000, 3, 0, P_B0);
    set_i1(1, 0, 6, 5, 0, 0, 3'b100, 1, 0, P_B1);
    in_valid = 1'b1;
    step(1, 1, P_B0, 0, '0, 0);
    in_valid = 1'b0;
    repeat (3) idle(0);
    step(0, 0, '0, 1, P_B1, 0);
    check("stall_raw", 64'(stall_cycles), 64'd3);

    reset = 1'b0;
    idle(0);
    reset = 1'b1;

    // Scoreboard stall: r2 written with lat=4, next pair reads r2
    set_i0(0, 1, 2, 0, 0, 0, 3'b000, 4, 0, P_C0);
    set_i1(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, P_C1);
    in_valid = 1'b1;
    step(1, 1, P_C0, 1, P_C1, 0);
    set_i0(0, 0, 0, 2, 0, 0, 3'b100, 0, 0, P_C2);
    set_i1(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, P_C3);
    repeat (4) idle(0);
    step(1, 1, P_C2, 1, P_C3, 0);
    check("stall_sb", 64'(stall_cycles), 64'd4);

    // Same-pipe independent pair
    set_i0(0, 1, 20, 0, 0, 0, 3'b000, 1, 0, P_D0);
    set_i1(0, 1, 21, 0, 0, 0, 3'b000, 1, 0, P_D1);
    step(1, 1, P_D0, 0, '0, 0);
    in_valid = 1'b0;
    step(0, 1, P_D1, 0, '0, 0);

    // Branch-first dual pair, then a branch-first pair that cannot dual-issue
    set_i0(1, 0, 0, 0, 0, 0, 3'b000, 0, 1, P_E0);
    set_i1(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, P_E1);
    in_valid = 1'b1;
    step(1, 1, P_E1, 1, P_E0, 1);
    set_i0(1, 0, 0, 0, 0, 0, 3'b000, 0, 1, P_E2);
    set_i1(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, P_E3);
    step(1, 0, '0, 1, P_E2, 0);
    in_valid = 1'b0;
    step(0, 0, '0, 1, P_E3, 0);

    // Flush in RUN, then flush while a RAW-held instruction waits
    set_i0(0, 1, 7, 0, 0, 0, 3'b000, 5, 0, P_F0);
    set_i1(1, 0, 0, 7, 0, 0, 3'b100, 0, 0, P_F1);
    in_valid = 1'b1;
    branch_taken = 1'b1;
    idle(0);
    branch_taken = 1'b0;
    idle(0);
    step(1, 1, P_F0, 0, '0, 0);
    in_valid = 1'b0;
    idle(0);
    branch_taken = 1'b1;
    idle(0);
    branch_taken = 1'b0;
    idle(0);
    set_i0(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, P_F2);
    set_i1(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, P_F3);
    in_valid = 1'b1;
    step(1, 1, P_F3, 1, P_F2, 0);
    in_valid = 1'b0;
    repeat (6) idle(0);
    check("stall_flush", 64'(stall_cycles), 64'd5);

    // Reset while holding with a live scoreboard entry
    set_i0(0, 1, 9, 0, 0, 0, 3'b000, 7, 0, P_G0);
    set_i1(1, 0, 0, 9, 0, 0, 3'b100, 0, 0, P_G1);
    in_valid = 1'b1;
    step(1, 1, P_G0, 0, '0, 0);
    idle(0);
    reset = 1'b0;
    idle(0);
    check("rst_hold_even_payload", even_payload, '0);
    check("rst_hold_odd_payload", odd_payload, '0);
    check("rst_hold_stall", 64'(stall_cycles), 64'd0);
    reset = 1'b1;
    set_i0(0, 0, 0, 9, 0, 0, 3'b100, 0, 0, P_G2);
    set_i1(1, 0, 0, 9, 0, 0, 3'b100, 0, 0, P_G3);
    step(1, 1, P_G2, 1, P_G3, 0);
    in_valid = 1'b0;
    idle(0);
    check("post_rst_stall", 64'(stall_cycles), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dual_issue_ctrl.md
DUAL_ISSUE_CTRL -- requirements
Module: dual_issue_ctrl

Interface
REQ-001 Parameter PAYLOAD_W, default 64: width of the opaque instruction payload (opcode, immediates, addresses) passed to each pipe.
REQ-002 Parameter REG_ADDR_WIDTH, default 7: register address width for 128 registers.
REQ-003 Parameter LAT_W, default 3: width of the latency field; maximum latency is 7.
REQ-004 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-low reset; asserted when 0.
REQ-006 Port in_valid  in  1  decode presents an in-order instruction pair (i0 older).
REQ-007 Port in_ready  out  1  pair consumed at this edge when in_valid=1 and in_ready=1.
REQ-008 Ports i0_/i1_ fields, all inputs, for each of the two instructions:
  - pipe (1; 0=even, 1=odd)
  - wr (1; writes rt)
  - rt, ra, rb, rc (REG_ADDR_WIDTH each)
  - use (3; bit2/1/0 = ra/rb/rc read)
  - lat (LAT_W; cycles until result is forwardable)
  - br (1; branch)
  - payload (PAYLOAD_W)
REQ-009 Port branch_taken  in  1  odd pipe reports a taken branch; flush request.
REQ-010 Port even_valid  out  1  registered; even_payload (PAYLOAD_W) is valid.
REQ-011 Port even_payload  out  PAYLOAD_W  registered; payload of the instruction issued to the even pipe.
REQ-012 Port odd_valid  out  1  registered; odd_payload (PAYLOAD_W) is valid.
REQ-013 Port odd_payload  out  PAYLOAD_W  registered; payload of the instruction issued to the odd pipe.
REQ-014 Port br_first_instr  out  1  registered; issued pair is dual and i0 is a branch.
REQ-015 Port stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-016 Scoreboard: 128 entries of LAT_W-bit countdown. A source is ready when its entry is 0 or its use bit is 0.
REQ-017 Every nonzero entry decrements by 1 each cycle.
REQ-018 An issuing instruction with wr=1 and lat>0 sets entry[rt] to max(decremented value, lat). Otherwise it leaves the entry unchanged.
REQ-019 The controller has three states:
  - RUN: accepts pairs; reset state.
  - HOLD: a leftover i1 is latched in the hold register.
  - FLUSH: one-cycle flush.
REQ-020 RUN, i0 issue: i0 issues when in_valid=1, all its sources are ready, and branch_taken=0.
REQ-021 RUN, in_ready: in_ready equals the i0-issue condition; i1 never issues without i0.
REQ-022 RUN, i1 dual-issues with i0 only if all of the following hold:
  - i1.pipe != i0.pipe
  - i1 sources are ready
  - i1 reads no register equal to i0.rt when i0.wr=1
  - not (both wr=1 and i1.rt == i0.rt)
REQ-023 RUN: if i0 issues and i1 does not, i1 is latched into the hold register and the state becomes HOLD.
REQ-024 HOLD: in_ready=0. The held instruction issues alone when its sources are ready and branch_taken=0, after which the state returns to RUN.
REQ-025 The scoreboard update for an instruction issued at edge t is visible to readiness checks from cycle t+1 onward.
REQ-026 A dependent instruction therefore waits exactly lat cycles after the producer's decision cycle.
REQ-027 Issue outputs appear on the edge after the decision cycle. Each payload is routed by its pipe bit; the valid of a pipe not issued that cycle is 0.
REQ-028 br_first_instr=1 only with dual issue and i0.br=1; it is 0 otherwise.
REQ-029 branch_taken=1 in any state has priority over every issue decision:
  - no issue; in_ready=0; next even_valid=odd_valid=0
  - hold register cleared
  - state goes to FLUSH
REQ-030 FLUSH: in_ready=0, no issue, next state RUN; the scoreboard keeps counting (conservative).
REQ-031 A stall cycle is one with no flush and no issue while either (RUN with in_valid=1) or HOLD holds. stall_cycles increments by 1 on each stall cycle and saturates at 0xFFFF.

Reset
REQ-032 reset=0 at a rising edge forces the following, overriding all other inputs including mid-HOLD or mid-FLUSH:
  - state RUN
  - all scoreboard entries 0
  - hold register empty
  - even_valid, odd_valid, br_first_instr 0
  - even_payload, odd_payload 0
  - stall_cycles 0
REQ-033 While reset=0, in_ready=0.

Verification
REQ-034 Independent pair (i0 even rt=3 lat=2; i1 odd rt=4 ra=10, rb=11) -> in_ready=1; next cycle even_valid=odd_valid=1 with correct payloads.
REQ-035 Intra-pair RAW (i0 even wr rt=5; i1 odd ra=5) -> even only next cycle, state HOLD; i1 issues on odd exactly lat(i0) cycles after the decision cycle.
REQ-036 Scoreboard stall (even rt=2 lat=4 issued; next pair i0 reads r2) -> in_ready=0 for 4 cycles, issue in the 5th; stall_cycles=4.
REQ-037 Same-pipe pair (both even, independent) -> i0 issues and i1 is held; i1 issues the next cycle; br_first_instr=0.
REQ-038 Dual pair with i0 odd br=1 -> br_first_instr=1. Separately, branch_taken=1 while in HOLD -> the held instruction is never issued, valids are 0, FLUSH then RUN.
REQ-039 Assert reset=0 during HOLD with nonzero scoreboard entries -> all outputs 0; the first pair after release issues without stall.
